// File: rtl/vram_arbiter.sv
// Arbitrates one single-port video RAM between VGA scan-out (fixed pixel slots) and CPU accesses.
// Optional macro VRAM_ARB_TEARFREE_EN holds CPU writes until vertical blanking (y >= 480).
module vram_arbiter #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 15,
  parameter int FB_WIDTH = 160,
  parameter int H_SHIFT  = 2,
  parameter int V_SHIFT  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p_tick,
  input  logic              video_on,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t            state, state_next;
  logic              disp_slot;
  logic              issue_ok;
  logic              issue_now;
  logic [ADDR_W-1:0] disp_addr;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              slot_d;
  logic              active_d;

  assign disp_slot = p_tick && video_on;
  assign disp_addr = ADDR_W'(y >> V_SHIFT) * ADDR_W'(FB_WIDTH) + ADDR_W'(x >> H_SHIFT);

`ifdef VRAM_ARB_TEARFREE_EN
  assign issue_ok = !disp_slot && (!cpu_we || (y >= 10'd480));
`else
  assign issue_ok = !disp_slot;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    cpu_ack    = 1'b0;
    issue_now  = 1'b0;
    case (state)
      IDLE:  if (cpu_req) state_next = ISSUE;
      ISSUE: if (issue_ok) begin
        issue_now  = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        cpu_ack    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Port is driven combinationally in the slot cycle so the synchronous RAM
  // returns data one clk later; otherwise address/data replay the held copy.
  always_comb begin
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_we    = 1'b0;
    if (!reset) begin
      if (disp_slot) begin
        mem_addr = disp_addr;
      end else if (issue_now) begin
        mem_addr  = cpu_addr;
        mem_we    = cpu_we;
        mem_wdata = cpu_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      cpu_rdata <= '0;
    end else begin
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
      if (state == DONE && !cpu_we) cpu_rdata <= mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_d    <= 1'b0;
      active_d  <= 1'b0;
      pix_data  <= '0;
      pix_valid <= 1'b0;
    end else begin
      slot_d   <= p_tick;
      active_d <= video_on;
      if (slot_d) begin
        pix_data  <= active_d ? mem_rdata : '0;
        pix_valid <= active_d;
      end
    end
  end

endmodule
